// File: rtl/keccak_arbiter.sv
// Two-requester round-robin front end for a single Keccak core.
// One requester at a time is granted the core: the core is cleared with a
// one-cycle k_reset, the granted requester's words are streamed into it, and
// the arbiter then waits for the digest (bounded by a watchdog).
//
// Ports
//   clk, reset                  clock, asynchronous active-low reset
//   reqN_valid/data/last/byte_num   requester N word offer (N = 0, 1)
//   reqN_ready                  word accepted when valid & ready
//   reqN_digest                 registered digest of N's last completed message
//   reqN_done / reqN_err        one-cycle completion pulse / timeout qualifier
//   k_reset                     core synchronous reset (high in CLEAR and in reset)
//   k_in/k_in_ready/k_is_last/k_byte_num   core word interface
//   k_buffer_full/k_out/k_out_ready        core status and digest
module keccak_arbiter #(
  parameter int unsigned WDOG_CYCLES = 4096,
  parameter int unsigned WDOG_W      = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [31:0]  req0_data,
  input  logic         req0_last,
  input  logic [1:0]   req0_byte_num,
  output logic         req0_ready,
  output logic [511:0] req0_digest,
  output logic         req0_done,
  output logic         req0_err,
  input  logic         req1_valid,
  input  logic [31:0]  req1_data,
  input  logic         req1_last,
  input  logic [1:0]   req1_byte_num,
  output logic         req1_ready,
  output logic [511:0] req1_digest,
  output logic         req1_done,
  output logic         req1_err,
  output logic         k_reset,
  output logic [31:0]  k_in,
  output logic         k_in_ready,
  output logic         k_is_last,
  output logic [1:0]   k_byte_num,
  input  logic         k_buffer_full,
  input  logic [511:0] k_out,
  input  logic         k_out_ready
);

  typedef enum logic [1:0] {StIdle, StClear, StFeed, StWait} state_e;

  state_e              state_q;
  logic                grant_q;       // 0 = req0, 1 = req1
  logic                last_grant_q;
  logic [WDOG_W-1:0]   wdog_q;
  logic                k_reset_q;
  logic [1:0]          done_q;
  logic [1:0]          err_q;
  logic [511:0]        digest0_q;
  logic [511:0]        digest1_q;

  logic                arb_grant;
  logic                g_valid;
  logic [31:0]         g_data;
  logic                g_last;
  logic [1:0]          g_byte_num;
  logic                feed;
  logic                g_ready;
  logic                xfer;

  // Tie goes to the requester that was not served last.
  always_comb begin
    arb_grant = req1_valid;
    if (req0_valid && req1_valid) begin
      arb_grant = ~last_grant_q;
    end
  end

  always_comb begin
    g_valid    = grant_q ? req1_valid    : req0_valid;
    g_data     = grant_q ? req1_data     : req0_data;
    g_last     = grant_q ? req1_last     : req0_last;
    g_byte_num = grant_q ? req1_byte_num : req0_byte_num;
    feed       = (state_q == StFeed);
    g_ready    = feed & ~k_buffer_full;
    xfer       = g_valid & g_ready;
  end

  assign req0_ready  = g_ready & ~grant_q;
  assign req1_ready  = g_ready & grant_q;
  assign k_in_ready  = xfer;
  assign k_in        = feed ? g_data : 32'h0;
  assign k_is_last   = xfer & g_last;
  assign k_byte_num  = feed ? g_byte_num : 2'b00;
  assign k_reset     = k_reset_q;
  assign req0_done   = done_q[0];
  assign req1_done   = done_q[1];
  assign req0_err    = err_q[0];
  assign req1_err    = err_q[1];
  assign req0_digest = digest0_q;
  assign req1_digest = digest1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wdog_q       <= '0;
      k_reset_q    <= 1'b1;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
      digest0_q    <= '0;
      digest1_q    <= '0;
    end else begin
      k_reset_q <= 1'b0;
      done_q    <= 2'b00;
      err_q     <= 2'b00;
      case (state_q)
        StIdle: begin
          // k_out_ready is deliberately ignored here; it may be stale.
          if (req0_valid || req1_valid) begin
            grant_q      <= arb_grant;
            last_grant_q <= arb_grant;
            k_reset_q    <= 1'b1;
            state_q      <= StClear;
          end
        end
        StClear: begin
          state_q <= StFeed;
        end
        StFeed: begin
          if (xfer && g_last) begin
            wdog_q  <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (k_out_ready) begin
            if (grant_q) begin
              digest1_q <= k_out;
            end else begin
              digest0_q <= k_out;
            end
            done_q[grant_q] <= 1'b1;
            state_q         <= StIdle;
          end else if (wdog_q == WDOG_W'(WDOG_CYCLES)) begin
            done_q[grant_q] <= 1'b1;
            err_q[grant_q]  <= 1'b1;
            state_q         <= StIdle;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_arbiter.sv
// Scoreboard bench for keccak_arbiter with a small behavioural Keccak-core
// stand-in whose "digest" is {word count, XOR of words, last byte_num}.
module tb_keccak_arbiter;

  localparam int unsigned Wdog = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_last, req0_ready, req0_done, req0_err;
  logic [31:0]  req0_data;
  logic [1:0]   req0_byte_num;
  logic [511:0] req0_digest;
  logic         req1_valid, req1_last, req1_ready, req1_done, req1_err;
  logic [31:0]  req1_data;
  logic [1:0]   req1_byte_num;
  logic [511:0] req1_digest;
  logic         k_reset, k_in_ready, k_is_last;
  logic [31:0]  k_in;
  logic [1:0]   k_byte_num;
  logic         k_buffer_full;
  logic [511:0] k_out = '0;
  logic         k_out_ready = 1'b0;

  keccak_arbiter #(.WDOG_CYCLES(Wdog), .WDOG_W(5)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last),
    .req0_byte_num(req0_byte_num), .req0_ready(req0_ready), .req0_digest(req0_digest),
    .req0_done(req0_done), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last),
    .req1_byte_num(req1_byte_num), .req1_ready(req1_ready), .req1_digest(req1_digest),
    .req1_done(req1_done), .req1_err(req1_err),
    .k_reset(k_reset), .k_in(k_in), .k_in_ready(k_in_ready), .k_is_last(k_is_last),
    .k_byte_num(k_byte_num), .k_buffer_full(k_buffer_full), .k_out(k_out),
    .k_out_ready(k_out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stand-in: digest ready 3 cycles after the last word unless hung.
  logic [31:0] core_x = '0;
  logic [15:0] core_n = '0;
  logic [1:0]  core_bn = '0;
  int          core_cnt = 0;
  logic        core_hang = 1'b0;
  always @(posedge clk) begin
    if (k_reset) begin
      core_x <= '0; core_n <= '0; core_bn <= '0; core_cnt <= 0;
      k_out_ready <= 1'b0; k_out <= '0;
    end else if (k_in_ready) begin
      core_x <= core_x ^ k_in;
      core_n <= core_n + 16'd1;
      if (k_is_last) begin
        core_bn  <= k_byte_num;
        core_cnt <= 3;
      end
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1 && !core_hang) begin
        k_out_ready <= 1'b1;
        k_out <= {416'h0, 16'h0, core_n, core_x, 30'h0, core_bn};
      end
    end
  end

  typedef struct {
    int           id;
    logic         err;
    logic [511:0] dig;
    logic         lat;
    logic         clr;
  } exp_t;

  exp_t         sb[$];
  logic [511:0] shadow [2];
  logic [31:0]  mem [64];
  int checks = 0;
  int failures = 0;
  int xfers = 0;
  int kres_cnt = 0;
  int last_xfer_cyc = 0;
  int clear_due = -1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input logic [511:0] act, input logic [511:0] req);
    failures++;
    $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  function automatic logic [511:0] dig_of(input int base, input int n, input logic [1:0] bn);
    logic [31:0] x = '0;
    for (int i = 0; i < n; i++) x ^= mem[base+i];
    return {416'h0, 16'h0, 16'(n), x, 30'h0, bn};
  endfunction

  task automatic expect_msg(input int id, input int base, input int n, input logic [1:0] bn,
                            input logic err, input logic lat, input logic clr);
    exp_t e;
    e.id = id; e.err = err; e.lat = lat; e.clr = clr;
    if (err) begin
      e.dig = shadow[id];
    end else begin
      e.dig = dig_of(base, n, bn);
      shadow[id] = e.dig;
    end
    sb.push_back(e);
  endtask

  task automatic drive(input int id, input logic v, input logic [31:0] d, input logic l,
                       input logic [1:0] bn);
    if (id == 0) begin
      req0_valid = v; req0_data = d; req0_last = l; req0_byte_num = bn;
    end else begin
      req1_valid = v; req1_data = d; req1_last = l; req1_byte_num = bn;
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic send(input int id, input int base, input int n, input logic [1:0] bn,
                      output int first_cyc);
    first_cyc = -1;
    for (int i = 0; i < n; i++) begin
      int k = 0;
      drive(id, 1'b1, mem[base+i], (i == n-1), (i == n-1) ? bn : 2'b00);
      do begin
        @(negedge clk);
        k++;
      end while (!rdy(id) && k < 300);
      if (!rdy(id)) begin
        checks++;
        fail_now("handshake_timeout", 512'(id), 512'(i));
        drive(id, 1'b0, 32'h0, 1'b0, 2'b00);
        return;
      end
      if (i == 0) first_cyc = cyc;
      @(posedge clk);
      #1;
    end
    drive(id, 1'b0, 32'h0, 1'b0, 2'b00);
  endtask

  task automatic wait_sb_empty();
    int k = 0;
    while (sb.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      checks++;
      fail_now("scoreboard_drain", 512'(sb.size()), 512'(0));
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (k_in_ready) xfers++;
        if (k_in_ready && k_is_last) last_xfer_cyc = cyc;
        if (k_reset) kres_cnt++;
        check("err_only_with_done",
              512'((req0_err & ~req0_done) | (req1_err & ~req1_done)), 512'(0));
        check("single_ready", 512'(req0_ready & req1_ready), 512'(0));
        if (k_buffer_full)
          check("stall_when_full", 512'(k_in_ready | req0_ready | req1_ready), 512'(0));
        if (cyc == clear_due) begin
          check("clear_after_done", 512'(k_reset), 512'(1));
          clear_due = -1;
        end
        for (int id = 0; id < 2; id++) begin
          if ((id == 0) ? req0_done : req1_done) begin
            checks++;
            if (sb.size() == 0) begin
              fail_now("unexpected_done", 512'(id), 512'(0));
            end else begin
              exp_t e;
              e = sb.pop_front();
              check("done_requester", 512'(id), 512'(e.id));
              check("done_err", 512'((id == 0) ? req0_err : req1_err), 512'(e.err));
              check("digest", (id == 0) ? req0_digest : req1_digest, e.dig);
              if (e.lat) check("timeout_latency", 512'(cyc - last_xfer_cyc), 512'(18));
              if (e.clr) clear_due = cyc + 1;
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual %0d required %0d", cyc, 0);
    $fatal(1, "bench timeout");
  end

  initial begin
    int fc, t, x0, k0, k;
    reset = 1'b0;
    k_buffer_full = 1'b0;
    drive(0, 1'b0, 32'h0, 1'b0, 2'b00);
    drive(1, 1'b0, 32'h0, 1'b0, 2'b00);
    shadow[0] = '0;
    shadow[1] = '0;
    mem[0] = "The "; mem[1] = "quic"; mem[2] = "k br"; mem[3] = "own ";
    mem[4] = "fox "; mem[5] = "jump"; mem[6] = "s ov"; mem[7] = "er t";
    mem[8] = "he l"; mem[9] = "azy "; mem[10] = "dog ";
    mem[11] = "Hell"; mem[12] = "o, w";
    for (int i = 13; i < 64; i++) mem[i] = 32'(i) * 32'h9E3779B9;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_k_reset", 512'(k_reset), 512'(1));
    check("rst_ready", 512'({req0_ready, req1_ready}), 512'(0));
    check("rst_done_err", 512'({req0_done, req1_done, req0_err, req1_err}), 512'(0));
    check("rst_digests", req0_digest | req1_digest, 512'(0));
    check("rst_core_word", 512'({k_in, k_in_ready, k_is_last, k_byte_num}), 512'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("k_reset_after_release", 512'(k_reset), 512'(0));

    // Tie: req0 first, then req1 with CLEAR right after req0's done, then req0 again
    expect_msg(0, 16, 3, 2'd1, 1'b0, 1'b0, 1'b1);
    expect_msg(1, 20, 2, 2'd2, 1'b0, 1'b0, 1'b0);
    fork
      begin int f; send(0, 16, 3, 2'd1, f); end
      begin int f; send(1, 20, 2, 2'd2, f); end
    join
    expect_msg(0, 24, 2, 2'd0, 1'b0, 1'b0, 1'b0);
    send(0, 24, 2, 2'd0, fc);
    wait_sb_empty();

    // Fox message with latency, k_reset pulse and transfer counts
    k0 = kres_cnt;
    x0 = xfers;
    t = cyc;
    drive(0, 1'b1, mem[0], 1'b0, 2'b00);
    @(negedge clk);
    check("idle_no_k_reset", 512'(k_reset), 512'(0));
    @(negedge clk);
    check("clear_k_reset", 512'(k_reset), 512'(1));
    check("clear_not_ready", 512'(req0_ready), 512'(0));
    expect_msg(0, 0, 11, 2'd3, 1'b0, 1'b0, 1'b0);
    send(0, 0, 11, 2'd3, fc);
    check("first_accept_cycle", 512'(fc - t), 512'(2));
    wait_sb_empty();
    check("fox_k_reset_pulses", 512'(kres_cnt - k0), 512'(1));
    check("fox_transfers", 512'(xfers - x0), 512'(11));

    // Buffer full for 20 cycles mid-message on req1
    x0 = xfers;
    expect_msg(1, 28, 5, 2'd2, 1'b0, 1'b0, 1'b0);
    fork
      send(1, 28, 5, 2'd2, fc);
      begin
        k = 0;
        while (xfers < x0 + 2 && k < 200) begin
          @(negedge clk);
          k++;
        end
        @(posedge clk);
        #1;
        k_buffer_full = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        k_buffer_full = 1'b0;
      end
    join
    wait_sb_empty();
    check("full_transfers", 512'(xfers - x0), 512'(5));

    // Watchdog timeout on req0, then req1 is served normally
    core_hang = 1'b1;
    expect_msg(0, 34, 2, 2'd1, 1'b1, 1'b1, 1'b0);
    send(0, 34, 2, 2'd1, fc);
    wait_sb_empty();
    core_hang = 1'b0;
    expect_msg(1, 37, 3, 2'd3, 1'b0, 1'b0, 1'b0);
    send(1, 37, 3, 2'd3, fc);
    wait_sb_empty();

    // Reset mid-FEED aborts the message
    drive(0, 1'b1, mem[11], 1'b0, 2'b00);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!req0_ready && k < 50);
    check("hello_first_accept", 512'(req0_ready), 512'(1));
    @(posedge clk);
    #1;
    drive(0, 1'b1, mem[12], 1'b1, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_k_reset", 512'(k_reset), 512'(1));
    check("abort_ready", 512'({req0_ready, req1_ready, k_in_ready, k_is_last}), 512'(0));
    check("abort_core_word", 512'({k_in, k_byte_num}), 512'(0));
    check("abort_digests", req0_digest | req1_digest, 512'(0));
    shadow[0] = '0;
    shadow[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_k_reset_held", 512'(k_reset), 512'(1));
    check("abort_no_done", 512'({req0_done, req1_done}), 512'(0));
    drive(0, 1'b0, 32'h0, 1'b0, 2'b00);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("k_reset_after_abort", 512'(k_reset), 512'(0));
    expect_msg(0, 11, 2, 2'd2, 1'b0, 1'b0, 1'b0);
    send(0, 11, 2, 2'd2, fc);
    wait_sb_empty();

    // Tie after req0 was served last: req1 wins
    expect_msg(1, 41, 2, 2'd1, 1'b0, 1'b0, 1'b1);
    expect_msg(0, 44, 1, 2'd0, 1'b0, 1'b0, 1'b0);
    fork
      begin int f; send(0, 44, 1, 2'd0, f); end
      begin int f; send(1, 41, 2, 2'd1, f); end
    join
    wait_sb_empty();
    check("final_digest0", req0_digest, shadow[0]);
    check("final_digest1", req1_digest, shadow[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
